mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the instruction-fetch (I) and data (D) ports onto
// one shared 64-bit memory port. Only one transaction is in flight at a time.
//
// D normally wins a conflict. A saturating streak counter limits how many
// D grants in a row can go by while I is waiting (STARVE_MAX, 1..7).
//
// Ports
//   clk, rst_n         : clock; asynchronous active-low reset
//   i_req/i_addr       : fetch request and word address [31:2]
//   i_ready/i_rdata    : one-cycle completion pulse and the selected 32-bit word
//   d_req/d_wen/d_addr/d_wdata : data request (1 = write)
//   d_ready/d_rdata    : one-cycle completion pulse and 64-bit read data
//   m_req/m_wen/m_addr/m_wdata : shared-memory request, driven from latched state only
//   m_rdata/m_ack      : shared-memory read data and one-cycle completion
//   stall              : a requester is waiting and has not been answered this cycle
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:2] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:2] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        m_req,
    output logic        m_wen,
    output logic [31:2] m_addr,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        m_ack,
    output logic        stall
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  streak_q, streak_d;
    logic        resp_is_d_q, resp_is_d_d;  // which port RESP answers
    logic [31:2] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            resp_is_d_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            resp_is_d_q <= resp_is_d_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        resp_is_d_d = resp_is_d_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || streak_q < STARVE_LIM)) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr;
                    wen_d   = d_wen;
                    wdata_d = d_wdata;
                    // Count only D grants that actually made I wait.
                    if (i_req && streak_q != 3'd7)
                        streak_d = streak_q + 3'd1;
                end else if (i_req) begin
                    state_d  = BUSY_I;
                    addr_d   = i_addr;
                    streak_d = '0;
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    // addr_q[2] is byte-address bit 2: picks the 32-bit half.
                    i_rdata_d   = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
                    resp_is_d_d = 1'b0;
                    state_d     = RESP;
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    if (!wen_q)
                        d_rdata_d = m_rdata;
                    resp_is_d_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign m_wen   = (state_q == BUSY_D) && wen_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_ready = (state_q == RESP) && !resp_is_d_q;
    assign d_ready = (state_q == RESP) && resp_is_d_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign stall   = (i_req && !i_ready) || (d_req && !d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand sequences for
// fairness, slow memory, dropped request, stray ack and async reset. Expected
// read data is queued when a request is driven and popped when a ready pulses.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_wen = 1'b0, m_ack = 1'b0;
    logic [31:2] i_addr = '0, d_addr = '0;
    logic [63:0] d_wdata = '0, m_rdata = '0;
    logic        i_ready, d_ready, m_req, m_wen, stall;
    logic [31:0] i_rdata;
    logic [63:0] d_rdata, m_wdata;
    logic [31:2] m_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall)
    );

    int vec_cnt = 0, err_cnt = 0;
    int rdy_pulses = 0, hold_cycles = 0;
    logic [63:0] i_exp_q[$], d_exp_q[$];
    logic [31:0] last_i = '0;
    logic [63:0] last_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for m_req, check the latched request, answer after lat cycles.
    task automatic serve(input int lat, input logic [63:0] rd, input logic [31:2] ea,
                         input logic ew, input logic [63:0] ewd, input bit cw,
                         output int n);
        n = 0;
        hold_cycles = 0;
        while (!m_req && n < 50) begin tick(); n++; end
        chk("m_req_seen", m_req, 1);
        if (m_req) begin
            chk("m_addr", m_addr, ea);
            chk("m_wen", m_wen, ew);
            if (cw) chk("m_wdata", m_wdata, ewd);
            for (int k = 0; k < lat; k++) begin
                if (m_req && stall) hold_cycles++;
                tick();
            end
            m_ack = 1'b1; m_rdata = rd;
            tick();
            m_ack = 1'b0; m_rdata = '0;
        end
    endtask

    // Scoreboard side: every ready pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_ready) begin
                rdy_pulses++;
                if (i_exp_q.size() == 0) chk("i_ready_unexpected", 1, 0);
                else chk("i_rdata", {32'h0, i_rdata}, i_exp_q.pop_front());
            end
            if (d_ready) begin
                rdy_pulses++;
                if (d_exp_q.size() == 0) chk("d_ready_unexpected", 1, 0);
                else chk("d_rdata", d_rdata, d_exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        is_d;
        logic        wen;
        logic [31:2] addr;
        logic [63:0] wdata;
        logic [63:0] mrd;
        int          lat;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vt[7];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] mrd;
        logic [31:0] hi, lo;
        logic is_d;
        logic order[6];
        int p0;

        //          is_d  wen   addr             wdata                  mrd                    lat exp_rd
        vt[0] = '{1'b0, 1'b0, 30'h0,          64'h0,                 64'hAAAA_BBBB_CCCC_DDDD, 2, 64'hCCCC_DDDD};
        vt[1] = '{1'b0, 1'b0, 30'h3,          64'h0,                 64'hAAAA_BBBB_CCCC_DDDD, 2, 64'hAAAA_BBBB};
        vt[2] = '{1'b1, 1'b1, 30'h10,         64'h1234,              64'h5555_5555_5555_5555, 0, 64'h0};
        vt[3] = '{1'b1, 1'b0, 30'h20,         64'h0,                 64'h1122_3344_5566_7788, 1, 64'h1122_3344_5566_7788};
        vt[4] = '{1'b1, 1'b1, 30'h21,         64'hFFFF_0000_FFFF_0000, 64'h9999_9999_9999_9999, 3, 64'h1122_3344_5566_7788};
        vt[5] = '{1'b0, 1'b0, 30'h7,          64'h0,                 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567};
        vt[6] = '{1'b0, 1'b0, 30'h3FFF_FFFF,  64'h0,                 64'hFEDC_BA98_7654_3210, 1, 64'hFEDC_BA98};

        // Reset state, before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_m_wen", m_wen, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single transactions from the table.
        foreach (vt[v]) begin
            if (vt[v].is_d) begin
                d_req = 1'b1; d_wen = vt[v].wen; d_addr = vt[v].addr; d_wdata = vt[v].wdata;
                d_exp_q.push_back(vt[v].exp_rd);
                last_d = vt[v].exp_rd;
            end else begin
                i_req = 1'b1; i_addr = vt[v].addr;
                i_exp_q.push_back(vt[v].exp_rd);
                last_i = vt[v].exp_rd[31:0];
            end
            #1 chk("stall_on_req", stall, 1);
            serve(vt[v].lat, vt[v].mrd, vt[v].addr, vt[v].is_d & vt[v].wen, vt[v].wdata, vt[v].is_d, n);
            chk("grant_latency", n, 1);
            chk("ready_pulse", vt[v].is_d ? d_ready : i_ready, 1);
            chk("stall_at_ready", stall, 0);
            i_req = 1'b0; d_req = 1'b0;
            tick();
            chk("ready_one_cycle", i_ready | d_ready, 0);
            chk("i_rdata_hold", i_rdata, last_i);
            chk("d_rdata_hold", d_rdata, last_d);
        end

        // Fairness: both ports held, immediate ack.
        order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        i_req = 1'b1; i_addr = 30'h40;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 30'h80; d_wdata = '0;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (!m_req && n < 20) begin tick(); n++; end
            chk("fair_m_req", m_req, 1);
            is_d = (m_addr == 30'h80);
            chk("grant_order", is_d, order[g]);
            hi = 32'hA000_0000 + 32'(g);
            lo = 32'hB000_0000 + 32'(g);
            mrd = {hi, lo};
            if (is_d) begin d_exp_q.push_back(mrd); last_d = mrd; end
            else begin i_exp_q.push_back({32'h0, lo}); last_i = lo; end
            m_ack = 1'b1; m_rdata = mrd;
            tick();
            m_ack = 1'b0; m_rdata = '0;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();

        // Slow memory: 20 cycles of m_req with stall held, exactly one pulse.
        p0 = rdy_pulses;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 30'h33; d_wdata = 64'h0;
        mrd = 64'h0BAD_F00D_1357_9BDF;
        d_exp_q.push_back(mrd); last_d = mrd;
        serve(20, mrd, 30'h33, 1'b0, 64'h0, 1'b1, n);
        chk("slow_hold_cycles", hold_cycles, 20);
        chk("slow_d_ready", d_ready, 1);
        d_req = 1'b0;
        repeat (3) tick();
        chk("slow_one_pulse", rdy_pulses - p0, 1);

        // Requester drops i_req while in flight: still completes.
        i_req = 1'b1; i_addr = 30'h3;
        i_exp_q.push_back(64'h1111_2222); last_i = 32'h1111_2222;
        tick();
        i_req = 1'b0;
        serve(2, 64'h1111_2222_3333_4444, 30'h3, 1'b0, 64'h0, 1'b0, n);
        chk("drop_i_ready", i_ready, 1);
        tick();

        // Stray ack while idle.
        m_ack = 1'b1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("stray_m_req", m_req, 0);
        chk("stray_ready", i_ready | d_ready, 0);
        tick();
        m_ack = 1'b0; m_rdata = '0;
        chk("stray_m_req2", m_req, 0);
        chk("stray_i_rdata", i_rdata, last_i);
        chk("stray_d_rdata", d_rdata, last_d);

        // Async reset in the middle of a D write, off the clock edge.
        d_req = 1'b1; d_wen = 1'b1; d_addr = 30'h55; d_wdata = 64'hCAFE;
        tick();
        chk("ar_busy", m_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_m_req", m_req, 0);
        chk("ar_m_wen", m_wen, 0);
        chk("ar_m_addr", m_addr, 0);
        chk("ar_m_wdata", m_wdata, 0);
        chk("ar_i_rdata", i_rdata, 0);
        chk("ar_d_rdata", d_rdata, 0);
        chk("ar_ready", i_ready | d_ready, 0);
        d_req = 1'b0;
        last_i = '0; last_d = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        m_ack = 1'b1; m_rdata = 64'h7777_7777_7777_7777;
        tick();
        m_ack = 1'b0; m_rdata = '0;
        chk("ar_late_ack_m_req", m_req, 0);
        chk("ar_late_ack_ready", i_ready | d_ready, 0);
        tick();
        chk("ar_late_ack_d_rdata", d_rdata, 0);
        chk("ar_late_ack_i_rdata", i_rdata, 0);

        chk("queue_drain", i_exp_q.size() + d_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
